// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/compare/shift ops, shift-add MUL and restoring DIV/REM.
// Latency: 1 cycle for single-cycle ops, divide-by-zero and illegal ops; WIDTH cycles for MUL and DIV/REM.
// Backpressure: in_ready is low while busy or while a held result is not being consumed; outputs hold until out_ready.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       AluOP,
    input  logic [WIDTH-1:0] Op1,
    input  logic [WIDTH-1:0] Op2,
    input  logic [SHW-1:0]   Shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             Cond,
    output logic             Err
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_MUL  = 6'b000010;
    localparam logic [5:0] OP_DIV  = 6'b000011, OP_REM  = 6'b000100, OP_AND  = 6'b000101;
    localparam logic [5:0] OP_OR   = 6'b000110, OP_XOR  = 6'b000111, OP_NOT  = 6'b001000;
    localparam logic [5:0] OP_BLT  = 6'b001001, OP_SLT  = 6'b001010, OP_SGT  = 6'b001011;
    localparam logic [5:0] OP_SGE  = 6'b001100, OP_BEQ  = 6'b001101, OP_BNQ  = 6'b001110;
    localparam logic [5:0] OP_BLTZ = 6'b001111, OP_BGTZ = 6'b010001, OP_BGZ  = 6'b010010;
    localparam logic [5:0] OP_SRL  = 6'b010011, OP_SLL  = 6'b010100, OP_SRA  = 6'b010101;

    typedef enum logic [1:0] {S_IDLE, S_MULB, S_DIVB} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;       // {partial sum, remaining multiplier bits}
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;       // dividend shifts out of the top, quotient bits in at the bottom
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               isrem_q, isrem_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               zero_q, zero_d, cond_q, cond_d, err_q, err_d, ovld_q, ovld_d;

    logic [WIDTH-1:0]   res;
    logic               rcond, rerr, is_mul, is_div, is_cmp, accept;
    logic [WIDTH:0]     mul_sum, div_sh;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   div_diff, rem_n, quo_n;
    logic               div_ge;

    assign in_ready  = (state_q == S_IDLE) && (!ovld_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = ovld_q;
    assign Out       = out_q;
    assign Zero      = zero_q;
    assign Cond      = cond_q;
    assign Err       = err_q;

    // One multiply step: conditionally add multiplicand to the upper half, then shift right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // One restoring divide step; the partial remainder stays below the divisor so the difference fits WIDTH bits.
    assign div_sh   = {rem_q, quo_q[WIDTH-1]};
    assign div_ge   = (div_sh >= {1'b0, dvs_q});
    assign div_diff = div_sh[WIDTH-1:0] - dvs_q;
    assign rem_n    = div_ge ? div_diff : div_sh[WIDTH-1:0];
    assign quo_n    = {quo_q[WIDTH-2:0], div_ge};

    // Decode the request and compute every single-cycle result, including divide-by-zero.
    always_comb begin
        res    = '0;
        rcond  = 1'b0;
        rerr   = 1'b0;
        is_mul = 1'b0;
        is_div = 1'b0;
        is_cmp = 1'b0;
        case (AluOP)
            OP_ADD:  res = Op1 + Op2;
            OP_SUB:  res = Op1 - Op2;
            OP_MUL:  is_mul = 1'b1;
            OP_DIV:  if (Op2 == '0) begin res = '1;  rerr = 1'b1; end else is_div = 1'b1;
            OP_REM:  if (Op2 == '0) begin res = Op1; rerr = 1'b1; end else is_div = 1'b1;
            OP_AND:  res = Op1 & Op2;
            OP_OR:   res = Op1 | Op2;
            OP_XOR:  res = Op1 ^ Op2;
            OP_NOT:  res = ~Op1;
            OP_BLT:  begin is_cmp = 1'b1; rcond = $signed(Op1) <  $signed(Op2); end
            OP_SLT:  begin is_cmp = 1'b1; rcond = $signed(Op1) <= $signed(Op2); end
            OP_SGT:  begin is_cmp = 1'b1; rcond = $signed(Op1) >  $signed(Op2); end
            OP_SGE:  begin is_cmp = 1'b1; rcond = $signed(Op1) >= $signed(Op2); end
            OP_BEQ:  begin is_cmp = 1'b1; rcond = (Op1 == Op2); end
            OP_BNQ:  begin is_cmp = 1'b1; rcond = (Op1 != Op2); end
            OP_BLTZ: begin is_cmp = 1'b1; rcond = Op1[WIDTH-1]; end
            OP_BGTZ: begin is_cmp = 1'b1; rcond = !Op1[WIDTH-1] && (Op1 != '0); end
            OP_BGZ:  begin is_cmp = 1'b1; rcond = !Op1[WIDTH-1]; end
            OP_SRL:  res = Op1 >> Shamt;
            OP_SLL:  res = Op1 << Shamt;
            OP_SRA:  res = $signed(Op1) >>> Shamt;
            default: rerr = 1'b1;
        endcase
        if (is_cmp) res = {{(WIDTH-1){1'b0}}, rcond};
    end

    // Next-state and datapath updates: accept in IDLE, iterate in MULB/DIVB, write result on completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        isrem_d = isrem_q;
        out_d   = out_q;
        zero_d  = zero_q;
        cond_d  = cond_q;
        err_d   = err_q;
        ovld_d  = ovld_q && !out_ready;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d = S_MULB;
                        cnt_d   = CW'(WIDTH);
                        acc_d   = {{WIDTH{1'b0}}, Op2};
                        mcand_d = Op1;
                        ovld_d  = 1'b0;
                    end else if (is_div) begin
                        state_d = S_DIVB;
                        cnt_d   = CW'(WIDTH);
                        quo_d   = Op1;
                        rem_d   = '0;
                        dvs_d   = Op2;
                        isrem_d = (AluOP == OP_REM);
                        ovld_d  = 1'b0;
                    end else begin
                        out_d  = res;
                        zero_d = (res == '0);
                        cond_d = rcond;
                        err_d  = rerr;
                        ovld_d = 1'b1;
                    end
                end
            end
            S_MULB: begin
                cnt_d = cnt_q - CW'(1);
                acc_d = mul_next;
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    out_d   = mul_next[WIDTH-1:0];
                    zero_d  = (mul_next[WIDTH-1:0] == '0);
                    cond_d  = 1'b0;
                    err_d   = 1'b0;
                    ovld_d  = 1'b1;
                end
            end
            S_DIVB: begin
                cnt_d = cnt_q - CW'(1);
                rem_d = rem_n;
                quo_d = quo_n;
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    out_d   = isrem_q ? rem_n : quo_n;
                    zero_d  = ((isrem_q ? rem_n : quo_n) == '0);
                    cond_d  = 1'b0;
                    err_d   = 1'b0;
                    ovld_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            isrem_q <= 1'b0;
            out_q   <= '0;
            zero_q  <= 1'b1;
            cond_q  <= 1'b0;
            err_q   <= 1'b0;
            ovld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            isrem_q <= isrem_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            cond_q  <= cond_d;
            err_q   <= err_d;
            ovld_q  <= ovld_d;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a 32-bit and an 8-bit instance driven by directed steps and a short random run.
// Expected results are queued at accept and popped when the DUT presents a result.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, Zero, Cond, Err;
    logic [5:0]  AluOP;
    logic [31:0] Op1, Op2, Out;
    logic [4:0]  Shamt;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, Zero8, Cond8, Err8;
    logic [5:0]  AluOP8;
    logic [7:0]  Op1_8, Op2_8, Out8;
    logic [2:0]  Shamt8;

    int ncmp = 0;
    int nfail = 0;

    typedef struct {
        string       tag;
        logic [31:0] out;
        logic        cond;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    logic [5:0] oplist [0:23] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9,
                                  6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17, 6'd18,
                                  6'd19, 6'd20, 6'd21, 6'd22, 6'd63};

    alu_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .AluOP(AluOP),
        .Op1(Op1), .Op2(Op2), .Shamt(Shamt), .out_valid(out_valid), .out_ready(out_ready),
        .Out(Out), .Zero(Zero), .Cond(Cond), .Err(Err)
    );

    alu_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .AluOP(AluOP8),
        .Op1(Op1_8), .Op2(Op2_8), .Shamt(Shamt8), .out_valid(out_valid8), .out_ready(out_ready8),
        .Out(Out8), .Zero(Zero8), .Cond(Cond8), .Err(Err8)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of the 32-bit ALU, written from the opcode table.
    function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, output logic [31:0] o, output logic c,
                                  output logic e, output int lat);
        o = '0; c = 1'b0; e = 1'b0; lat = 0;
        case (op)
            6'd0:  o = a + b;
            6'd1:  o = a - b;
            6'd2:  begin o = a * b; lat = 32; end
            6'd3:  if (b == 0) begin o = 32'hFFFF_FFFF; e = 1'b1; end else begin o = a / b; lat = 32; end
            6'd4:  if (b == 0) begin o = a; e = 1'b1; end else begin o = a % b; lat = 32; end
            6'd5:  o = a & b;
            6'd6:  o = a | b;
            6'd7:  o = a ^ b;
            6'd8:  o = ~a;
            6'd9:  c = $signed(a) <  $signed(b);
            6'd10: c = $signed(a) <= $signed(b);
            6'd11: c = $signed(a) >  $signed(b);
            6'd12: c = $signed(a) >= $signed(b);
            6'd13: c = (a == b);
            6'd14: c = (a != b);
            6'd15: c = $signed(a) < 0;
            6'd17: c = $signed(a) > 0;
            6'd18: c = $signed(a) >= 0;
            6'd19: o = a >> sh;
            6'd20: o = a << sh;
            6'd21: o = $signed(a) >>> sh;
            default: e = 1'b1;
        endcase
        if (op inside {[6'd9:6'd15], 6'd17, 6'd18}) o = {31'b0, c};
    endfunction

    task automatic check_front(input logic [31:0] o, input logic z, input logic c, input logic e,
                               input int n, input int busy);
        exp_t x;
        chk("sb.depth", 32'(sbq.size() > 0), 32'd1);
        if (sbq.size() > 0) begin
            x = sbq.pop_front();
            chk({x.tag, ".out"},  o, x.out);
            chk({x.tag, ".zero"}, 32'(z), 32'(x.out == 0));
            chk({x.tag, ".cond"}, 32'(c), 32'(x.cond));
            chk({x.tag, ".err"},  32'(e), 32'(x.err));
            chk({x.tag, ".lat"},  32'(n), 32'(x.lat));
            chk({x.tag, ".busy"}, 32'(busy), 32'(x.lat));
        end
    endtask

    // Issue one request to the 32-bit ALU at a falling edge and collect its result.
    task automatic send(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [31:0] eo, input logic ec, input logic ee,
                        input int elat);
        int n, busy;
        chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
        AluOP = op; Op1 = a; Op2 = b; Shamt = sh; in_valid = 1'b1;
        sbq.push_back('{tag, eo, ec, ee, elat});
        @(negedge clk);
        in_valid = 1'b0;
        Op1 = $urandom; Op2 = $urandom; Shamt = 5'($urandom); AluOP = 6'($urandom);
        n = 0; busy = 0;
        while (!out_valid && n < 100) begin
            if (!in_ready) busy++;
            @(negedge clk);
            n++;
        end
        check_front(Out, Zero, Cond, Err, n, busy);
    endtask

    task automatic send8(input string tag, input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] sh, input logic [7:0] eo, input int elat);
        int n, busy;
        chk({tag, ".rdy"}, 32'(in_ready8), 32'd1);
        AluOP8 = op; Op1_8 = a; Op2_8 = b; Shamt8 = sh; in_valid8 = 1'b1;
        sbq.push_back('{tag, {24'b0, eo}, 1'b0, 1'b0, elat});
        @(negedge clk);
        in_valid8 = 1'b0;
        n = 0; busy = 0;
        while (!out_valid8 && n < 100) begin
            if (!in_ready8) busy++;
            @(negedge clk);
            n++;
        end
        check_front({24'b0, Out8}, Zero8, Cond8, Err8, n, busy);
    endtask

    initial begin
        logic [31:0] a, b, eo;
        logic [5:0]  op;
        logic [4:0]  sh;
        logic        ec, ee;
        int          elat, seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; AluOP = '0; Op1 = '0; Op2 = '0; Shamt = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; AluOP8 = '0; Op1_8 = '0; Op2_8 = '0; Shamt8 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state of both instances.
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready",  32'(in_ready),  32'd1);
        chk("rst.out",       Out,            32'd0);
        chk("rst.zero",      32'(Zero),      32'd1);
        chk("rst.cond",      32'(Cond),      32'd0);
        chk("rst.err",       32'(Err),       32'd0);
        chk("rst8.out_valid", 32'(out_valid8), 32'd0);
        chk("rst8.zero",      32'(Zero8),      32'd1);

        // Back-to-back single-cycle ops: ADD then SUB accepted on the next edge.
        AluOP = 6'd0; Op1 = 32'h7FFF_FFFF; Op2 = 32'd1; in_valid = 1'b1;
        sbq.push_back('{"b2b.add", 32'h8000_0000, 1'b0, 1'b0, 0});
        @(negedge clk);
        chk("b2b.add_vld", 32'(out_valid), 32'd1);
        chk("b2b.rdy2",    32'(in_ready),  32'd1);
        AluOP = 6'd1; Op1 = 32'd5; Op2 = 32'd5;
        sbq.push_back('{"b2b.sub", 32'd0, 1'b0, 1'b0, 0});
        check_front(Out, Zero, Cond, Err, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b.sub_vld", 32'(out_valid), 32'd1);
        check_front(Out, Zero, Cond, Err, 0, 0);
        @(negedge clk);
        chk("b2b.drained", 32'(out_valid), 32'd0);

        // Multi-cycle and single-cycle directed cases.
        send("mul",   6'd2,  32'hFFFF_FFFF, 32'd3, 5'd0, 32'hFFFF_FFFD, 1'b0, 1'b0, 32);
        send("div",   6'd3,  32'd100, 32'd7, 5'd0, 32'd14, 1'b0, 1'b0, 32);
        send("rem",   6'd4,  32'd100, 32'd7, 5'd0, 32'd2,  1'b0, 1'b0, 32);
        send("div0",  6'd3,  32'd9,   32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 0);
        send("rem0",  6'd4,  32'd9,   32'd0, 5'd0, 32'd9,  1'b0, 1'b1, 0);
        send("sge",   6'd12, 32'hFFFF_FFFF, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 0);
        send("blt",   6'd9,  32'hFFFF_FFFF, 32'd0, 5'd0, 32'd1, 1'b1, 1'b0, 0);
        send("slt_eq",6'd10, 32'd5, 32'd5, 5'd0, 32'd1, 1'b1, 1'b0, 0);
        send("sra",   6'd21, 32'h8000_0000, 32'd0, 5'd4, 32'hF800_0000, 1'b0, 1'b0, 0);
        send("srl",   6'd19, 32'h8000_0000, 32'd0, 5'd4, 32'h0800_0000, 1'b0, 1'b0, 0);
        send("ill63", 6'd63, 32'd1, 32'd2, 5'd0, 32'd0, 1'b0, 1'b1, 0);
        send("ill16", 6'd16, 32'd1, 32'd2, 5'd0, 32'd0, 1'b0, 1'b1, 0);
        @(negedge clk);

        // Held result: outputs stay put and no new request is admitted.
        out_ready = 1'b0;
        send("hold", 6'd0, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold.out",   Out,               32'd7);
            chk("hold.vld",   32'(out_valid),    32'd1);
            chk("hold.rdy",   32'(in_ready),     32'd0);
            chk("hold.zero",  32'(Zero),         32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold.consumed", 32'(out_valid), 32'd0);

        // Reset in the middle of a divide aborts it.
        AluOP = 6'd3; Op1 = 32'd100; Op2 = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort.busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.vld",  32'(out_valid), 32'd0);
        chk("abort.rdy",  32'(in_ready),  32'd1);
        chk("abort.out",  Out,            32'd0);
        chk("abort.zero", 32'(Zero),      32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort.no_result", 32'(seen), 32'd0);

        // Random requests checked against the reference model, issued back to back.
        for (int i = 0; i < 24; i++) begin
            op = oplist[$urandom_range(0, 23)];
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            sh = 5'($urandom_range(0, 31));
            model(op, a, b, sh, eo, ec, ee, elat);
            send($sformatf("rnd%0d_op%0d", i, op), op, a, b, sh, eo, ec, ee, elat);
        end

        // 8-bit instance.
        send8("w8.mul", 6'd2,  8'd15,  8'd17, 3'd0, 8'hFF, 8);
        send8("w8.sll", 6'd20, 8'h01,  8'd0,  3'd7, 8'h80, 0);
        send8("w8.div", 6'd3,  8'd200, 8'd7,  3'd0, 8'd28, 8);
        send8("w8.rem", 6'd4,  8'd200, 8'd7,  3'd0, 8'd4,  8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
